// File: rtl/lsu_pkg.sv
// Shared definitions for the dm_lsu load/store unit: RV32I funct3 codes,
// FSM state encoding and the funct3 legality helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Unsigned variants only exist for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for dm_lsu: load extract/extend, store lane merge and
// alignment check. Purely combinational; lanes are little-endian.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_dm_rd,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_load_data,
    output logic [XLEN-1:0] o_wr_data,
    output logic            o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte      = i_dm_rd[{i_addr_lo, 3'b000} +: 8];
        w_half      = i_dm_rd[{i_addr_lo[1], 4'b0000} +: 16];
        o_load_data = '0;
        o_wr_data   = i_dm_rd;
        o_misalign  = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
                o_wr_data[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            end
            F3_BU: o_load_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_H: begin
                o_load_data = {{(XLEN-16){w_half[15]}}, w_half};
                o_wr_data[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
                o_misalign  = i_addr_lo[0];
            end
            F3_HU: begin
                o_load_data = {{(XLEN-16){1'b0}}, w_half};
                o_misalign  = i_addr_lo[0];
            end
            F3_W: begin
                o_load_data = i_dm_rd;
                o_wr_data   = i_wdata;
                o_misalign  = |i_addr_lo;
            end
            default: o_load_data = '0;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: RV32I load/store unit driving a single-port word-addressed DM.
// Optional macro DM_LSU_RANGE_CHECK_EN flags addresses beyond the DM as errors.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | DM addressed, checks evaluated, store written at exit
// RESP   | response held until rsp_ready
module dm_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addres,
    output logic [XLEN-1:0]   dm_wd,
    input  logic [XLEN-1:0]   dm_rd
);

    lsu_state_e      r_state, w_next;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_rsp_err;

    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_merged;
    logic            w_misalign;
    logic            w_range_err;
    logic            w_err;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_funct3    (r_funct3),
        .i_addr_lo   (r_addr[1:0]),
        .i_dm_rd     (dm_rd),
        .i_wdata     (r_wdata),
        .o_load_data (w_load),
        .o_wr_data   (w_merged),
        .o_misalign  (w_misalign)
    );

`ifdef DM_LSU_RANGE_CHECK_EN
    assign w_range_err = |r_addr[XLEN-1:ADDR_W+2];
`else
    // Upper bits are ignored so accesses wrap onto the DM.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^r_addr[XLEN-1:ADDR_W+2];
    assign w_range_err      = 1'b0;
`endif

    assign w_err     = !f3_legal(r_we, r_funct3) || w_misalign || w_range_err;
    assign dm_addres = r_addr[ADDR_W+1:2];
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        dm_we     = 1'b0;
        dm_wd     = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = ACCESS;
            end
            ACCESS: begin
                w_next = RESP;
                if (r_we && !w_err) begin
                    dm_we = 1'b1;
                    dm_wd = w_merged;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            if (r_state == ACCESS) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || r_we) ? '0 : w_load;
            end
        end
    end

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu with a byte-array reference model of the DM.
module tb_dm_lsu;

    localparam int ADDR_W = 5;
    localparam int XLEN   = 32;
    localparam int NBYTES = 4 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = '0;
    logic [XLEN-1:0]   req_addr = '0;
    logic [XLEN-1:0]   req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addres;
    logic [XLEN-1:0]   dm_wd;
    logic [XLEN-1:0]   dm_rd;

    dm_lsu #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dm_we(dm_we), .dm_addres(dm_addres), .dm_wd(dm_wd), .dm_rd(dm_rd)
    );

    always #5 clk = ~clk;

    // Data memory
    logic [XLEN-1:0] tb_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (dm_we) tb_mem[dm_addres] <= dm_wd;
    assign dm_rd = tb_mem[dm_addres];

    typedef struct { logic [31:0] rdata; logic err; } rsp_t;
    typedef struct { logic [ADDR_W-1:0] idx; logic [31:0] data; } wr_t;
    rsp_t exp_q[$];
    wr_t  wr_q[$];
    logic [7:0] mbytes [0:NBYTES-1];

    int checks = 0;
    int errors = 0;
    bit bp_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic abort(input string name);
        errors++;
        checks++;
        $display("FAIL %s: timed out", name);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    endtask

    function automatic logic [31:0] model_word(input int idx);
        return {mbytes[4*idx+3], mbytes[4*idx+2], mbytes[4*idx+1], mbytes[4*idx]};
    endfunction

    // Reference: byte-addressed memory, RV32I rules applied directly.
    function automatic void model_issue(input logic we, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] wd);
        int   sz, n, base;
        bit   err;
        rsp_t r;
        wr_t  w;
        logic [31:0] v;
        sz  = int'(f3[1:0]);
        err = we ? !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                 : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!err && sz == 1 && (a % 2) != 0) err = 1;
        if (!err && sz == 2 && (a % 4) != 0) err = 1;
`ifdef DM_LSU_RANGE_CHECK_EN
        if (a >= NBYTES) err = 1;
`endif
        base = int'(a % NBYTES);
        n    = 1 << sz;
        r.rdata = 0;
        r.err   = err;
        if (!err && we) begin
            for (int i = 0; i < n; i++) mbytes[base+i] = wd[8*i +: 8];
            w.idx  = ADDR_W'(base / 4);
            w.data = model_word(base / 4);
            wr_q.push_back(w);
        end else if (!err) begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (32'(mbytes[base+i]) << (8*i));
            if (f3[2] == 1'b0 && sz == 0 && v[7])  v = v | 32'hFFFF_FF00;
            if (f3[2] == 1'b0 && sz == 1 && v[15]) v = v | 32'hFFFF_0000;
            r.rdata = v;
        end
        exp_q.push_back(r);
    endfunction

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        while (!req_ready) begin
            @(negedge clk);
            n++;
            if (n > 300) abort("issue_wait_ready");
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        model_issue(we, f3, a, wd);
        @(posedge clk);
        #1;
        // Junk while busy must be ignored.
        req_valid = $urandom_range(0, 1); req_we = $urandom_range(0, 1);
        req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) abort("drain");
        req_valid = 1'b0;
    endtask

    // Response monitor
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b with nothing pending", rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp: got rdata=%h err=%b expected rdata=%h err=%b",
                             rsp_rdata, rsp_err, e.rdata, e.err);
                end
            end
        end
    end

    // Write monitor
    always @(negedge clk) begin
        wr_t w;
        if (rst_n && dm_we) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL dm_we_unexpected: got idx=%0d wd=%h with no write pending", dm_addres, dm_wd);
            end else begin
                w = wr_q.pop_front();
                if (dm_addres !== w.idx || dm_wd !== w.data) begin
                    errors++;
                    $display("FAIL dm_write: got idx=%0d wd=%h expected idx=%0d wd=%h",
                             dm_addres, dm_wd, w.idx, w.data);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_rand) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int n;
        logic [31:0] a, wd;
        logic [2:0]  f3;
        logic        we;

        for (int i = 0; i < (1 << ADDR_W); i++) begin
            tb_mem[i] = $urandom;
            for (int b = 0; b < 4; b++) mbytes[4*i+b] = tb_mem[i][8*b +: 8];
        end
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err",   32'(rsp_err), 32'd0);
        check("rst_dm_we",     32'(dm_we), 32'd0);
        check("rst_dm_addres", 32'(dm_addres), 32'd0);
        check("rst_dm_wd",     dm_wd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed
        issue(1, 3'b010, 32'h28, 32'h0000_0019);
        issue(0, 3'b010, 32'h28, 32'h0);
        drain();
        check("sw_word10", tb_mem[10], 32'h0000_0019);
        issue(1, 3'b010, 32'h3C, 32'h1122_3344);
        issue(1, 3'b000, 32'h3E, 32'h0000_00AB);
        issue(0, 3'b000, 32'h3E, 32'h0);
        issue(0, 3'b100, 32'h3E, 32'h0);
        drain();
        check("sb_word15", tb_mem[15], 32'h11AB_3344);
        issue(1, 3'b001, 32'h3C, 32'h0000_8001);
        issue(0, 3'b001, 32'h3C, 32'h0);
        issue(0, 3'b101, 32'h3C, 32'h0);
        drain();
        check("sh_word15", tb_mem[15], 32'h11AB_8001);
        issue(0, 3'b010, 32'h29, 32'h0);
        issue(1, 3'b001, 32'h3D, 32'hFFFF_FFFF);
        issue(1, 3'b011, 32'h3C, 32'hFFFF_FFFF);
        issue(0, 3'b110, 32'h3C, 32'h0);
        drain();
        check("err_word15", tb_mem[15], 32'h11AB_8001);
        issue(1, 3'b010, 32'h80, 32'h5A5A_0001);
        issue(0, 3'b010, 32'h00, 32'h0);
        drain();
        check("range_word0", tb_mem[0], model_word(0));

        // Backpressure and latency
        rsp_ready = 1'b0;
        issue(0, 3'b010, 32'h28, 32'h0);
        @(negedge clk);
        check("lat_access_valid", 32'(rsp_valid), 32'd0);
        check("lat_access_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("lat_resp_valid", 32'(rsp_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rdata", rsp_rdata, exp_q[0].rdata);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_back_idle", 32'(req_ready), 32'd1);
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        req_valid = 1'b0;

        // Reset during the ACCESS cycle of a store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = ~model_word(4);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst_mid_dm_we_before", 32'(dm_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_dm_we", 32'(dm_we), 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_dm_addres", 32'(dm_addres), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_mem", tb_mem[4], model_word(4));
        rst_n = 1'b1;

        // Random traffic
        bp_rand = 1'b1;
        for (int k = 0; k < 300; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
                 (we ? 3'($urandom_range(0, 2)) : (($urandom_range(0, 1) == 1) ? 3'($urandom_range(4, 5)) : 3'($urandom_range(0, 2))));
            a  = 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 15) == 0) a = a | ($urandom << (ADDR_W + 2)) | 32'h8000_0000;
            wd = $urandom;
            issue(we, f3, a, wd);
        end
        drain();
        bp_rand = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) if (tb_mem[i] !== model_word(i)) n++;
        check("final_mem_mismatches", 32'(n), 32'd0);
        check("final_wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
